// File: rtl/mux41_src_scan_if.sv
// Bus bundle between the source-register bank / select sequencer and its
// user. The master side writes registers, requests scans and consumes the
// mux output. The slave side is the sequencer itself.
//
// Handshake: out_valid is raised by the slave and stays high, with the
// select held stable, until a rising clk edge sees out_valid && out_ready.
// That edge is the transfer. out_ready may be driven freely by the master
// and never feeds back into out_valid combinationally.
interface mux41_src_scan_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic [3:0]       scan_mask;
    logic             out_ready;

    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] a3;
    logic             s1;
    logic             s0;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    modport master (
        output wr_en, wr_addr, wr_data, start, scan_mask, out_ready,
        input  a0, a1, a2, a3, s1, s0, out_valid, busy, done, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, scan_mask, out_ready,
        output a0, a1, a2, a3, s1, s0, out_valid, busy, done, dbg_state
    );
endinterface

// File: rtl/mux41_src_scan.sv
// Source-register bank and select sequencer for an 8-bit 4:1 mux stage.
// Holds the four mux operands and, on start, walks the mux selects through
// the set bits of a latched mask in ascending order, offering each entry
// to the consumer with valid/ready. All outputs come straight from flops.
module mux41_src_scan #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    mux41_src_scan_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       m_q, m_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] regs_q [4];

    logic             handshake;
    logic [2:0]       first_hit;
    logic [2:0]       next_hit;

    // {found, index} of the lowest set bit of mask.
    function automatic logic [2:0] lowest_set(input logic [3:0] mask);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) res = {1'b1, i[1:0]};
        end
        return res;
    endfunction

    // {found, index} of the lowest set bit of mask strictly above cur.
    // No wrap: nothing at or below cur is ever considered.
    function automatic logic [2:0] next_above(input logic [3:0] mask,
                                              input logic [1:0] cur);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) res = {1'b1, i[1:0]};
        end
        return res;
    endfunction

    assign handshake = out_valid_q && bus.out_ready;
    assign first_hit = lowest_set(bus.scan_mask);
    assign next_hit  = next_above(m_q, idx_q);

    // Register bank: writes land in any state, reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else if (bus.wr_en) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            m_q         <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            m_q         <= m_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; status flags are decoded from the next state so
    // they register alongside it instead of being decoded after the flop.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        m_d     = m_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (first_hit[2]) begin
                        state_d = SCAN;
                        idx_d   = first_hit[1:0];
                        m_d     = bus.scan_mask;
                    end else begin
                        // Empty mask: report completion without presenting
                        // anything; idx keeps its previous value.
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (handshake) begin
                    if (next_hit[2]) begin
                        idx_d = next_hit[1:0];
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = (state_d == SCAN);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    assign bus.a0        = regs_q[0];
    assign bus.a1        = regs_q[1];
    assign bus.a2        = regs_q[2];
    assign bus.a3        = regs_q[3];
    assign bus.s1        = idx_q[1];
    assign bus.s0        = idx_q[0];
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux41_src_scan.sv
// Bench for mux41_src_scan. The downstream 4:1 mux is modelled here so the
// value a consumer would see on r can be compared against the bench's own
// register image and scan plan.
module tb_mux41_src_scan;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux41_src_scan_if #(.WIDTH(W)) bus ();

    mux41_src_scan #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Downstream mux and observation helpers.
    logic [W-1:0]   r;
    logic [1:0]     sel;
    logic [2:0]     flags;      // {out_valid, busy, done}
    logic [4*W-1:0] regs_obs;

    assign sel      = {bus.s1, bus.s0};
    assign flags    = {bus.out_valid, bus.busy, bus.done};
    assign regs_obs = {bus.a3, bus.a2, bus.a1, bus.a0};

    always_comb begin
        case (sel)
            2'd0:    r = bus.a0;
            2'd1:    r = bus.a1;
            2'd2:    r = bus.a2;
            default: r = bus.a3;
        endcase
    end

    // Reference model: register image, planned scan order, last index shown.
    logic [W-1:0] ref_regs [4];
    logic [1:0]   exp_q [$];
    logic [1:0]   last_sel;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [4*W-1:0] ref_pack();
        return {ref_regs[3], ref_regs[2], ref_regs[1], ref_regs[0]};
    endfunction

    // Scan order is simply the set mask bits, lowest first.
    function automatic void plan(input logic [3:0] mask);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) exp_q.push_back(i[1:0]);
        end
        if (exp_q.size() > 0) last_sel = exp_q[exp_q.size()-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 2'd0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.scan_mask = 4'd0;
        bus.out_ready = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [W-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        ref_regs[addr] = data;
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;
        last_sel = 2'd0;
        n_checks++;
        if (regs_obs !== ref_pack()) $display("FAIL reset_regs got=%h exp=%h", regs_obs, ref_pack());
        else n_pass++;
        n_checks++;
        if ({sel, flags} !== 5'b00_000) $display("FAIL reset_status got=%b exp=%b", {sel, flags}, 5'b00_000);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_writes();
        logic [W-1:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            write_reg(i[1:0], vals[i]);
            n_checks++;
            if (regs_obs !== ref_pack()) $display("FAIL write_%0d got=%h exp=%h", i, regs_obs, ref_pack());
            else n_pass++;
        end
        n_checks++;
        if ({sel, flags} !== 5'b00_000) $display("FAIL write_idle_status got=%b exp=%b", {sel, flags}, 5'b00_000);
        else n_pass++;
    endtask

    task automatic test_full_scan();
        plan(4'b1111);
        bus.start = 1'b1; bus.scan_mask = 4'b1111; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({flags, sel, r} !== {3'b110, exp_q[0], ref_regs[exp_q[0]]})
                $display("FAIL full_step%0d got=%b/%0d/%h exp=110/%0d/%h", i, flags, sel, r, exp_q[0], ref_regs[exp_q[0]]);
            else n_pass++;
            tick();
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (flags !== 3'b011) $display("FAIL full_done got=%b exp=011", flags);
        else n_pass++;
        bus.out_ready = 1'b0;
        tick();
        n_checks++;
        if (flags !== 3'b000) $display("FAIL full_idle got=%b exp=000", flags);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic ready;
        int   cyc;
        plan(4'b1010);
        bus.start = 1'b1; bus.scan_mask = 4'b1010; bus.out_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        ready = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            n_checks++;
            if ({flags, sel, r} !== {3'b110, exp_q[0], ref_regs[exp_q[0]]})
                $display("FAIL bp_cyc%0d got=%b/%0d/%h exp=110/%0d/%h", cyc, flags, sel, r, exp_q[0], ref_regs[exp_q[0]]);
            else n_pass++;
            bus.out_ready = ready;
            tick();
            if (ready) void'(exp_q.pop_front());
            ready = ~ready;
            cyc++;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (cyc >= 20) $display("FAIL bp_timeout got=%0d exp=<20", cyc);
        else n_pass++;
        n_checks++;
        if (flags !== 3'b011) $display("FAIL bp_done got=%b exp=011", flags);
        else n_pass++;
        tick();
        n_checks++;
        if (flags !== 3'b000) $display("FAIL bp_single_done got=%b exp=000", flags);
        else n_pass++;
    endtask

    task automatic test_zero_mask();
        bus.start = 1'b1; bus.scan_mask = 4'b0000;
        tick();
        bus.start = 1'b0;
        n_checks++;
        if ({flags, sel} !== {3'b011, last_sel}) $display("FAIL zero_done got=%b/%0d exp=011/%0d", flags, sel, last_sel);
        else n_pass++;
        tick();
        n_checks++;
        if (flags !== 3'b000) $display("FAIL zero_idle got=%b exp=000", flags);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        plan(4'b0011);
        bus.start = 1'b1; bus.scan_mask = 4'b0011; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        // DONE cycle: a start here must be dropped, not queued.
        n_checks++;
        if (flags !== 3'b011) $display("FAIL b2b_done got=%b exp=011", flags);
        else n_pass++;
        bus.start = 1'b1; bus.scan_mask = 4'b1111;
        tick();
        n_checks++;
        if (flags !== 3'b000) $display("FAIL b2b_ignored got=%b exp=000", flags);
        else n_pass++;
        plan(4'b1111);
        tick();
        bus.start = 1'b0;
        n_checks++;
        if ({flags, sel} !== {3'b110, exp_q[0]}) $display("FAIL b2b_restart got=%b/%0d exp=110/%0d", flags, sel, exp_q[0]);
        else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (flags !== 3'b000) $display("FAIL b2b_end got=%b exp=000", flags);
        else n_pass++;
    endtask

    task automatic test_write_during_scan();
        plan(4'b1111);
        bus.start = 1'b1; bus.scan_mask = 4'b1111; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        n_checks++;
        if ({flags, sel, r} !== {3'b110, 2'd2, ref_regs[2]})
            $display("FAIL wds_at2 got=%b/%0d/%h exp=110/2/%h", flags, sel, r, ref_regs[2]);
        else n_pass++;
        bus.out_ready = 1'b0;
        bus.start = 1'b1; bus.scan_mask = 4'b0001;
        write_reg(2'd2, 8'h5A);
        bus.start = 1'b0;
        n_checks++;
        if ({flags, sel, r} !== {3'b110, 2'd2, 8'h5A})
            $display("FAIL wds_new got=%b/%0d/%h exp=110/2/5a", flags, sel, r);
        else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        n_checks++;
        if ({flags, sel, r} !== {3'b110, exp_q[0], ref_regs[exp_q[0]]})
            $display("FAIL wds_next got=%b/%0d/%h exp=110/%0d/%h", flags, sel, r, exp_q[0], ref_regs[exp_q[0]]);
        else n_pass++;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (flags !== 3'b011) $display("FAIL wds_done got=%b exp=011", flags);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        plan(4'b1111);
        bus.start = 1'b1; bus.scan_mask = 4'b1111; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if ({flags, sel} !== {3'b110, 2'd1}) $display("FAIL rms_at1 got=%b/%0d exp=110/1", flags, sel);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;
        last_sel = 2'd0;
        n_checks++;
        if ({regs_obs, sel, flags} !== {ref_pack(), 2'd0, 3'b000})
            $display("FAIL rms_async got=%h/%0d/%b exp=%h/0/000", regs_obs, sel, flags, ref_pack());
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (flags !== 3'b000) $display("FAIL rms_no_done got=%b exp=000", flags);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) write_reg(i[1:0], W'($urandom_range(0, 255)));
        plan(4'b0110);
        bus.start = 1'b1; bus.scan_mask = 4'b0110; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({flags, sel, r} !== {3'b110, exp_q[0], ref_regs[exp_q[0]]})
                $display("FAIL rms_fresh%0d got=%b/%0d/%h exp=110/%0d/%h", i, flags, sel, r, exp_q[0], ref_regs[exp_q[0]]);
            else n_pass++;
            tick();
            void'(exp_q.pop_front());
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (flags !== 3'b011) $display("FAIL rms_fresh_done got=%b exp=011", flags);
        else n_pass++;
        tick();
    endtask

    task automatic test_random_scans();
        logic [3:0]   mask;
        logic         ready;
        logic         wr;
        logic [1:0]   waddr;
        logic [W-1:0] wdata;
        int           cyc;
        for (int it = 0; it < 25; it++) begin
            mask = 4'($urandom_range(0, 15));
            plan(mask);
            bus.start = 1'b1; bus.scan_mask = mask;
            tick();
            bus.start = 1'b0;
            cyc = 0;
            if (mask == 4'd0) begin
                n_checks++;
                if ({flags, sel} !== {3'b011, last_sel}) $display("FAIL rnd%0d_zero got=%b/%0d exp=011/%0d", it, flags, sel, last_sel);
                else n_pass++;
            end else begin
                while (exp_q.size() > 0 && cyc < 60) begin
                    n_checks++;
                    if ({flags, sel, r} !== {3'b110, exp_q[0], ref_regs[exp_q[0]]})
                        $display("FAIL rnd%0d_cyc%0d got=%b/%0d/%h exp=110/%0d/%h", it, cyc, flags, sel, r, exp_q[0], ref_regs[exp_q[0]]);
                    else n_pass++;
                    ready = 1'($urandom_range(0, 1));
                    wr    = ($urandom_range(0, 2) == 0);
                    waddr = 2'($urandom_range(0, 3));
                    wdata = W'($urandom_range(0, 255));
                    bus.out_ready = ready;
                    bus.wr_en = wr; bus.wr_addr = waddr; bus.wr_data = wdata;
                    bus.start = 1'($urandom_range(0, 1));
                    bus.scan_mask = 4'($urandom_range(0, 15));
                    tick();
                    if (wr) ref_regs[waddr] = wdata;
                    if (ready) void'(exp_q.pop_front());
                    cyc++;
                end
                idle_inputs();
                n_checks++;
                if (cyc >= 60) $display("FAIL rnd%0d_timeout got=%0d exp=<60", it, cyc);
                else n_pass++;
                n_checks++;
                if ({flags, sel} !== {3'b011, last_sel}) $display("FAIL rnd%0d_done got=%b/%0d exp=011/%0d", it, flags, sel, last_sel);
                else n_pass++;
            end
            tick();
            n_checks++;
            if ({flags, regs_obs} !== {3'b000, ref_pack()})
                $display("FAIL rnd%0d_idle got=%b/%h exp=000/%h", it, flags, regs_obs, ref_pack());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_full_scan();
        test_backpressure();
        test_zero_mask();
        test_back_to_back();
        test_write_during_scan();
        test_reset_mid_scan();
        test_random_scans();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
